se_selfcomp_monitor: RTL and testbench
======================================

// Module: se_selfcomp_monitor
// PURPOSE
//  Output-side consumer for the two-copy SE self-composition harness. Sinks the result
//  handshakes of both SE instances and times each copy's latency from one shared issue
//  event. Flags a timing leak when the two copies finish in different cycles.
//  Sits beside the issue logic; its ready_* outputs drive the SE out_ready inputs.
// PARAMETERS
//  DATA_W    128  result width per copy
//  CNT_W     8    latency counter / latency output width
//  TIMEOUT   200  WAIT cycles before a missing result is declared (must be < 2^CNT_W-1)
//  SKEW_TOL  0    max |lat_one-lat_two| tolerated without a leak
// PORTS
//  clock          in   1       single clock, rising edge
//  reset          in   1       asynchronous, active-low; all state cleared while low
//  issue          in   1       SE input handshake fired (in_valid & in_ready) this cycle
//  clear          in   1       clears sticky timing_leak, timeout_err and overlap_err
//  valid_one      in   1       SE copy 1 result valid
//  result_one     in   DATA_W  SE copy 1 result
//  ready_one      out  1       accept copy 1 result
//  valid_two      in   1       SE copy 2 result valid
//  result_two     in   DATA_W  SE copy 2 result
//  ready_two      out  1       accept copy 2 result
//  lat_one        out  CNT_W   captured latency of copy 1, last transaction
//  lat_two        out  CNT_W   captured latency of copy 2, last transaction
//  res_one        out  DATA_W  captured result of copy 1, last transaction
//  res_two        out  DATA_W  captured result of copy 2, last transaction
//  timing_leak    out  1       sticky: some transaction violated SKEW_TOL or lost one copy
//  timing_leak_done out 1      one-cycle pulse: verdict for a transaction is valid
//  both_valid     out  1       valid_one & valid_two (combinational)
//  timeout_err    out  1       sticky: neither copy answered within TIMEOUT
//  overlap_err    out  1       sticky: issue seen while not IDLE
//  leak_count     out  8       saturating count of leaking transactions
// BEHAVIOUR
//  Reset: state=IDLE; every registered output, counter and got_* flag 0.
//  IDLE: ready_*=0. issue -> WAIT; cnt<=1, got_one=got_two=0.
//  WAIT: ready_x = !got_x. cnt increments each cycle, saturating at 2^CNT_W-1.
//   - valid_x & ready_x: got_x<=1, lat_x<=cnt, res_x<=result_x. Later valid_x ignored.
//   - Both accepted (same cycle or cumulatively) -> VERDICT.
//   - cnt==TIMEOUT, exactly one got -> VERDICT, missing lat_x<=all ones, leak forced.
//   - cnt==TIMEOUT, none got -> VERDICT, timeout_err<=1, no leak.
//  VERDICT (1 cycle): ready_*=0; timing_leak_done=1;
//   leak = forced | (both got & |lat_one-lat_two| > SKEW_TOL), computed in CNT_W+1 bits.
//   leak -> timing_leak<=1, leak_count+=1 (saturate 255). Next state IDLE.
//  Latency: result accepted in the cycle after issue gives lat=1.
//  issue in WAIT or VERDICT: ignored, overlap_err<=1, counter unaffected.
//  issue in the VERDICT cycle is not queued; harness keeps >=1 idle cycle.
//  clear and a same-cycle leak set: set wins. clear does not touch lat_*, res_*, leak_count.
//  Reset low mid-WAIT: immediate return to IDLE, in-flight transaction discarded.
//  Results are never compared for equality; only timing is judged.
// STRUCTURE
//  se_pkg: state enum {IDLE,WAIT,VERDICT}, default DATA_W/CNT_W, abs-diff function.
//  Sub-module se_lat_capture (one per copy): got flag, ready, lat/result capture,
//  cleared on issue. Top holds FSM, shared cnt, verdict, sticky flags, leak_count.
// TESTING
//  issue; valid_one,valid_two both at cycle 5 -> lat_one=lat_two=5, done pulse, leak=0.
//  issue; valid_one at 3, valid_two at 7, SKEW_TOL=0 -> lat 3/7, timing_leak=1, count=1.
//  SKEW_TOL=4, same stimulus -> no leak; SKEW_TOL=3 -> leak.
//  issue; only valid_one at 2 -> at cnt=TIMEOUT lat_two=8'hFF, leak=1, done pulse.
//  issue; no valids -> timeout_err=1, timing_leak=0; issue mid-WAIT -> overlap_err=1.
//  reset low during WAIT -> all outputs 0 next edge; clear with no leak -> flags 0.

Source files
------------

// File: rtl/se_pkg.sv
// Shared types and helpers for the SE self-composition timing monitor.
package se_pkg;

   localparam int DATA_W_DEF = 128;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      VERDICT = 2'd2
   } se_state_e;

   // Inputs are zero-extended latencies, so one extra bit holds any difference.
   function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      if (a >= b) begin
         r = {1'b0, a - b};
      end else begin
         r = {1'b0, b - a};
      end
      return r;
   endfunction

endpackage

// File: rtl/se_lat_capture.sv
// Per-copy result sink: tracks whether this copy answered and captures its latency and data.
module se_lat_capture
   import se_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_i,
   input  logic              wait_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              force_miss_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] result_i,
   output logic              ready_o,
   output logic              got_o,
   output logic              accept_o,
   output logic [CNT_W-1:0]  lat_o,
   output logic [DATA_W-1:0] res_o
);

   logic              got_q, got_d;
   logic [CNT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] res_q, res_d;

   assign ready_o  = wait_i & ~got_q;
   assign accept_o = valid_i & ready_o;
   assign got_o    = got_q;
   assign lat_o    = lat_q;
   assign res_o    = res_q;

   // Capture on first handshake; a copy still missing at timeout reports an all-ones latency.
   always_comb begin
      got_d = got_q;
      lat_d = lat_q;
      res_d = res_q;
      if (start_i) begin
         got_d = 1'b0;
      end else if (accept_o) begin
         got_d = 1'b1;
         lat_d = cnt_i;
         res_d = result_i;
      end else if (force_miss_i) begin
         lat_d = {CNT_W{1'b1}};
      end else begin
         got_d = got_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         got_q <= 1'b0;
         lat_q <= {CNT_W{1'b0}};
         res_q <= {DATA_W{1'b0}};
      end else begin
         got_q <= got_d;
         lat_q <= lat_d;
         res_q <= res_d;
      end
   end

endmodule

// File: rtl/se_selfcomp_monitor.sv
// Times both SE copies from a shared issue event and flags a timing leak when their
// completion cycles differ by more than SKEW_TOL or one copy never answers.
module se_selfcomp_monitor
   import se_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int TIMEOUT  = 200,
   parameter int SKEW_TOL = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue,
   input  logic              clear,
   input  logic              valid_one,
   input  logic [DATA_W-1:0] result_one,
   output logic              ready_one,
   input  logic              valid_two,
   input  logic [DATA_W-1:0] result_two,
   output logic              ready_two,
   output logic [CNT_W-1:0]  lat_one,
   output logic [CNT_W-1:0]  lat_two,
   output logic [DATA_W-1:0] res_one,
   output logic [DATA_W-1:0] res_two,
   output logic              timing_leak,
   output logic              timing_leak_done,
   output logic              both_valid,
   output logic              timeout_err,
   output logic              overlap_err,
   output logic [7:0]        leak_count
);

   se_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timing_leak_q, timing_leak_d;
   logic             timeout_err_q, timeout_err_d;
   logic             overlap_err_q, overlap_err_d;
   logic [7:0]       leak_count_q, leak_count_d;

   logic start_s, wait_s, verdict_s;
   logic got_one_s, got_two_s, acc_one_s, acc_two_s;
   logic miss_one_s, miss_two_s, to_set_s, leak_s;

   assign start_s   = (state_q == IDLE) & issue;
   assign wait_s    = (state_q == WAIT);
   assign verdict_s = (state_q == VERDICT);

   se_lat_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cap_one (
      .clock(clock), .reset(reset), .start_i(start_s), .wait_i(wait_s), .cnt_i(cnt_q),
      .force_miss_i(miss_one_s), .valid_i(valid_one), .result_i(result_one),
      .ready_o(ready_one), .got_o(got_one_s), .accept_o(acc_one_s),
      .lat_o(lat_one), .res_o(res_one)
   );

   se_lat_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cap_two (
      .clock(clock), .reset(reset), .start_i(start_s), .wait_i(wait_s), .cnt_i(cnt_q),
      .force_miss_i(miss_two_s), .valid_i(valid_two), .result_i(result_two),
      .ready_o(ready_two), .got_o(got_two_s), .accept_o(acc_two_s),
      .lat_o(lat_two), .res_o(res_two)
   );

   // Transaction FSM with shared latency counter and timeout resolution.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      miss_one_s = 1'b0;
      miss_two_s = 1'b0;
      to_set_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = WAIT;
               cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_d = cnt_q;
            end
            if ((got_one_s | acc_one_s) & (got_two_s | acc_two_s)) begin
               state_d = VERDICT;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d    = VERDICT;
               miss_two_s = got_one_s | acc_one_s;
               miss_one_s = got_two_s | acc_two_s;
               to_set_s   = ~(got_one_s | acc_one_s | got_two_s | acc_two_s);
            end else begin
               state_d = WAIT;
            end
         end
         VERDICT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A lone answer is always a leak; two answers leak only beyond the skew tolerance.
   assign leak_s = verdict_s & ((got_one_s ^ got_two_s) |
                   (got_one_s & got_two_s &
                    (abs_diff(32'(lat_one), 32'(lat_two)) > 33'(SKEW_TOL))));

   // Sticky error flags: a same-cycle set takes priority over clear.
   always_comb begin
      timing_leak_d = leak_s ? 1'b1 : (clear ? 1'b0 : timing_leak_q);
      timeout_err_d = to_set_s ? 1'b1 : (clear ? 1'b0 : timeout_err_q);
      overlap_err_d = (issue & ~(state_q == IDLE)) ? 1'b1 : (clear ? 1'b0 : overlap_err_q);
      if (leak_s && (leak_count_q != 8'hFF)) begin
         leak_count_d = leak_count_q + 8'd1;
      end else begin
         leak_count_d = leak_count_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         timing_leak_q <= 1'b0;
         timeout_err_q <= 1'b0;
         overlap_err_q <= 1'b0;
         leak_count_q  <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         timing_leak_q <= timing_leak_d;
         timeout_err_q <= timeout_err_d;
         overlap_err_q <= overlap_err_d;
         leak_count_q  <= leak_count_d;
      end
   end

   assign timing_leak      = timing_leak_q;
   assign timeout_err      = timeout_err_q;
   assign overlap_err      = overlap_err_q;
   assign leak_count       = leak_count_q;
   assign timing_leak_done = verdict_s;
   assign both_valid       = valid_one & valid_two;

endmodule

// File: tb/tb_se_selfcomp_monitor.sv
// Self-checking bench: three monitors (SKEW_TOL 0/4/3) share stimulus and are compared
// against a per-transaction model built from first-valid cycles of each copy.
module tb_se_selfcomp_monitor;

   localparam int DW = 128;
   localparam int CW = 8;
   localparam int TO = 200;
   localparam int NI = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic issue = 1'b0, clear = 1'b0, valid_one = 1'b0, valid_two = 1'b0;
   logic [DW-1:0] result_one = '0, result_two = '0;

   logic [NI-1:0]         ready_one_w, ready_two_w, done_w, both_w, leak_w, to_w, ov_w;
   logic [NI-1:0][CW-1:0] lat_one_w, lat_two_w;
   logic [NI-1:0][DW-1:0] res_one_w, res_two_w;
   logic [NI-1:0][7:0]    cnt_w;

   always #5 clock = ~clock;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      se_selfcomp_monitor #(
         .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO),
         .SKEW_TOL((g == 0) ? 0 : ((g == 1) ? 4 : 3))
      ) u_dut (
         .clock(clock), .reset(reset), .issue(issue), .clear(clear),
         .valid_one(valid_one), .result_one(result_one), .ready_one(ready_one_w[g]),
         .valid_two(valid_two), .result_two(result_two), .ready_two(ready_two_w[g]),
         .lat_one(lat_one_w[g]), .lat_two(lat_two_w[g]),
         .res_one(res_one_w[g]), .res_two(res_two_w[g]),
         .timing_leak(leak_w[g]), .timing_leak_done(done_w[g]), .both_valid(both_w[g]),
         .timeout_err(to_w[g]), .overlap_err(ov_w[g]), .leak_count(cnt_w[g])
      );
   end

   int errors = 0;
   int checks = 0;

   logic [CW-1:0] m_lat1 = '0, m_lat2 = '0;
   logic [DW-1:0] m_res1 = '0, m_res2 = '0;
   logic          m_leak [NI];
   int            m_cnt  [NI];
   logic          m_to = 1'b0, m_ov = 1'b0;

   function automatic int tol_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 4 : 3);
   endfunction

   // t == 0 means the copy never raises valid.
   function automatic bit answered(input int t);
      return (t != 0) && (t <= TO);
   endfunction

   function automatic int verdict_cycle(input int t1, input int t2);
      if (answered(t1) && answered(t2)) return ((t1 > t2) ? t1 : t2) + 1;
      return TO + 1;
   endfunction

   function automatic bit model_leak(input int t1, input int t2, input int tol);
      bit g1 = answered(t1);
      bit g2 = answered(t2);
      int d  = (t1 > t2) ? (t1 - t2) : (t2 - t1);
      if (g1 != g2) return 1'b1;
      if (g1 && g2) return d > tol;
      return 1'b0;
   endfunction

   task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_state();
      for (int i = 0; i < NI; i++) begin
         check("lat_one", i, DW'(lat_one_w[i]), DW'(m_lat1));
         check("lat_two", i, DW'(lat_two_w[i]), DW'(m_lat2));
         check("res_one", i, res_one_w[i], m_res1);
         check("res_two", i, res_two_w[i], m_res2);
         check("timing_leak", i, DW'(leak_w[i]), DW'(m_leak[i]));
         check("timeout_err", i, DW'(to_w[i]), DW'(m_to));
         check("overlap_err", i, DW'(ov_w[i]), DW'(m_ov));
         check("leak_count", i, DW'(cnt_w[i]), DW'(m_cnt[i]));
      end
   endtask

   // One transaction from IDLE: issue at cycle 0, copy x holds valid from cycle t_x on.
   task automatic run_txn(input int t1, input int t2, input int ov_at, input bit clr);
      int v = verdict_cycle(t1, t2);
      int seen = 0;
      int bad = 0;
      int c;
      logic [DW-1:0] cap1 = '0, cap2 = '0;
      bit g1 = answered(t1);
      bit g2 = answered(t2);
      issue = 1'b1; valid_one = 1'b0; valid_two = 1'b0; clear = 1'b0;
      @(negedge clock);
      for (c = 1; (c <= TO + 3) && (seen == 0); c++) begin
         issue      = (c == ov_at);
         valid_one  = (t1 != 0) && (c >= t1);
         valid_two  = (t2 != 0) && (c >= t2);
         result_one = {$urandom, $urandom, $urandom, $urandom};
         result_two = {$urandom, $urandom, $urandom, $urandom};
         if (c == t1) cap1 = result_one;
         if (c == t2) cap2 = result_two;
         clear = clr && (c == v);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (ready_one_w[i] !== ((c < v) && ((t1 == 0) || (c <= t1)))) bad++;
            if (ready_two_w[i] !== ((c < v) && ((t2 == 0) || (c <= t2)))) bad++;
            if (both_w[i] !== (valid_one & valid_two)) bad++;
            if (done_w[i] !== done_w[0]) bad++;
         end
         if (done_w[0] === 1'b1) seen = c;
         @(negedge clock);
      end
      issue = 1'b0; valid_one = 1'b0; valid_two = 1'b0; clear = 1'b0;
      #1;
      check("done_cycle", 0, DW'(seen), DW'(v));
      check("ready_bothvalid_errs", 0, DW'(bad), '0);
      if (g1) begin m_lat1 = CW'(t1); m_res1 = cap1; end
      else if (g2) m_lat1 = '1;
      if (g2) begin m_lat2 = CW'(t2); m_res2 = cap2; end
      else if (g1) m_lat2 = '1;
      if (!g1 && !g2) m_to = 1'b1;
      if (ov_at != 0) m_ov = 1'b1;
      if (clr) begin m_to = 1'b0; m_ov = 1'b0; end
      for (int i = 0; i < NI; i++) begin
         bit lk = model_leak(t1, t2, tol_of(i));
         m_leak[i] = lk | (m_leak[i] & ~clr);
         if (lk && (m_cnt[i] < 255)) m_cnt[i]++;
      end
      check_state();
      @(negedge clock);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      #1;
      m_to = 1'b0; m_ov = 1'b0;
      for (int i = 0; i < NI; i++) m_leak[i] = 1'b0;
      check_state();
      @(negedge clock);
   endtask

   function automatic int rand_t();
      int k = $urandom_range(0, 15);
      if (k == 0) return 0;
      if (k == 1) return $urandom_range(TO - 2, TO + 2);
      return $urandom_range(1, 12);
   endfunction

   typedef struct {
      int          t1;
      int          t2;
      logic [7:0]  lat1;
      logic [7:0]  lat2;
      logic [2:0]  leak;
      logic        to;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{t1: 5,  t2: 5, lat1: 8'd5,   lat2: 8'd5,   leak: 3'b000, to: 1'b0};
      vecs[1] = '{t1: 3,  t2: 7, lat1: 8'd3,   lat2: 8'd7,   leak: 3'b101, to: 1'b0};
      vecs[2] = '{t1: 2,  t2: 0, lat1: 8'd2,   lat2: 8'hFF,  leak: 3'b111, to: 1'b0};
      vecs[3] = '{t1: 0,  t2: 0, lat1: 8'd2,   lat2: 8'hFF,  leak: 3'b000, to: 1'b1};
      vecs[4] = '{t1: 1,  t2: 1, lat1: 8'd1,   lat2: 8'd1,   leak: 3'b000, to: 1'b0};
      vecs[5] = '{t1: TO, t2: 4, lat1: 8'd200, lat2: 8'd4,   leak: 3'b111, to: 1'b0};
      vecs[6] = '{t1: 3,  t2: 6, lat1: 8'd3,   lat2: 8'd6,   leak: 3'b001, to: 1'b0};
      for (int i = 0; i < NI; i++) begin m_leak[i] = 1'b0; m_cnt[i] = 0; end

      #1;
      check_state();
      for (int i = 0; i < NI; i++) check("reset_done", i, DW'(done_w[i]), '0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      for (int r = 0; r < 7; r++) begin
         do_clear();
         run_txn(vecs[r].t1, vecs[r].t2, 0, 1'b0);
         check("vec_lat_one", r, DW'(lat_one_w[0]), DW'(vecs[r].lat1));
         check("vec_lat_two", r, DW'(lat_two_w[0]), DW'(vecs[r].lat2));
         check("vec_timeout", r, DW'(to_w[0]), DW'(vecs[r].to));
         for (int i = 0; i < NI; i++)
            check("vec_leak", r * 10 + i, DW'(leak_w[i]), DW'(vecs[r].leak[i]));
      end

      do_clear();
      run_txn(4, 4, 2, 1'b0);
      run_txn(1, 5, 0, 1'b1);

      issue = 1'b1;
      @(negedge clock);
      issue = 1'b0; valid_one = 1'b1;
      @(negedge clock);
      valid_one = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      m_lat1 = '0; m_lat2 = '0; m_res1 = '0; m_res2 = '0; m_to = 1'b0; m_ov = 1'b0;
      for (int i = 0; i < NI; i++) begin m_leak[i] = 1'b0; m_cnt[i] = 0; end
      check_state();
      for (int i = 0; i < NI; i++) begin
         check("rst_ready_one", i, DW'(ready_one_w[i]), '0);
         check("rst_done", i, DW'(done_w[i]), '0);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_txn(2, 2, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         int t1 = rand_t();
         int t2 = rand_t();
         int v  = verdict_cycle(t1, t2);
         int ov = (($urandom_range(0, 7) == 0) && (v > 2)) ? $urandom_range(1, v - 1) : 0;
         run_txn(t1, t2, ov, $urandom_range(0, 5) == 0);
      end

      for (int n = 0; n < 260; n++) run_txn(1, 2, 0, 1'b0);
      check("leak_count_sat", 0, DW'(cnt_w[0]), DW'(8'hFF));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
